// File: rtl/nios_mul_combine_if.sv
// nios_mul_combine_if
// Bundles the M-stage operand/partial-product inputs and the W-stage result
// outputs of the multiplier combine stage. The CPU pipeline side is the
// master; the combine block is the slave.
interface nios_mul_combine_if;
    logic        en;
    logic        in_valid;
    logic        in_hi;
    logic [15:0] in_src1_hi;
    logic [15:0] in_src2_hi;
    logic [31:0] M_mul_cell_p1;
    logic [31:0] M_mul_cell_p2;
    logic [31:0] M_mul_cell_p3;
    logic        out_valid;
    logic [31:0] out_result;
    logic        busy;

    modport master (
        output en, in_valid, in_hi, in_src1_hi, in_src2_hi,
               M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        input  out_valid, out_result, busy
    );

    modport slave (
        input  en, in_valid, in_hi, in_src1_hi, in_src2_hi,
               M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        output out_valid, out_result, busy
    );
endinterface

// File: rtl/nios_mul_combine.sv
// nios_mul_combine
// Combines the Nios II multiplier cell's three 16x16 partial products
// (p1 = a_lo*b_lo, p2 = a_lo*b_hi, p3 = a_hi*b_lo) into the 32-bit low
// product through a two-stage pipeline that advances on en & ~busy.
//
// Optional feature, macro NIOS_MUL_COMBINE_MULHI_EN: adds an iterative
// shift-add a_hi*b_hi engine (16 cycles) that produces the unsigned high word
// (mulxuu). While that engine runs or waits to retire, busy stalls the CPU and
// both pipeline stages hold. With the macro undefined in_hi is ignored and busy
// is tied low.
module nios_mul_combine (
    input  logic                   clk,
    input  logic                   reset,
    nios_mul_combine_if.slave      bus
);

    // Stage 1 registers
    logic        v1;
    logic [31:0] p1_q;
    logic [32:0] mid;

    // Stage 2 registers
    logic        out_valid_q;
    logic [31:0] out_result_q;

    logic        busy_w;
    logic        load;
    logic [32:0] low_sum;
    logic        carry;

    assign load = bus.en & ~busy_w;

    // Low-word sum: p1 plus the low half of the middle terms shifted up 16.
    assign low_sum = {1'b0, p1_q} + {1'b0, mid[15:0], 16'h0000};
    assign carry   = low_sum[32];

`ifdef NIOS_MUL_COMBINE_MULHI_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        hi1;
    logic [31:0] acc;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic [3:0]  cnt;
    logic        start;
    logic        retire;
    logic [31:0] hi_result;

    // A high-word op enters ITER on the very edge stage 1 captures it, so
    // busy is high in the following cycle. The engine's mcand/mplier
    // registers are the stage-1 copy of the operand upper halves.
    assign start  = (state_q == IDLE) & load & bus.in_valid & bus.in_hi;
    assign retire = (state_q == DONE) & bus.en;
    assign busy_w = (state_q != IDLE);

    // High word = a_hi*b_hi + carries out of the low-word combination.
    assign hi_result = acc + {15'h0000, mid[32:16]} + {31'h0000_0000, carry};

    // FSM state register.
    // NOTE: every clocked block uses non-blocking (<=) assignments so all
    // registers sample pre-edge values and simulation matches the hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    // NOTE: state_d is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)            state_d = ITER;
            ITER:    if (cnt == 4'd15)     state_d = DONE;
            DONE:    if (bus.en)           state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // Shift-add engine: one multiplier bit per ITER cycle, en ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= bus.in_src1_hi;
            mplier <= bus.in_src2_hi;
            cnt    <= '0;
        end else if (state_q == ITER) begin
            if (mplier[0])
                acc <= acc + ({16'h0000, mcand} << cnt);
            mplier <= mplier >> 1;
            cnt    <= cnt + 4'd1;
        end
    end
`else
    assign busy_w = 1'b0;
`endif

    // Stage 1 capture; retiring a high-word op consumes the held entry.
    // NOTE: these are plain flops rather than a memory, so every one of them
    // takes the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1   <= 1'b0;
            p1_q <= '0;
            mid  <= '0;
`ifdef NIOS_MUL_COMBINE_MULHI_EN
            hi1  <= 1'b0;
`endif
        end else if (load) begin
            v1   <= bus.in_valid;
            p1_q <= bus.M_mul_cell_p1;
            mid  <= {1'b0, bus.M_mul_cell_p2} + {1'b0, bus.M_mul_cell_p3};
`ifdef NIOS_MUL_COMBINE_MULHI_EN
            hi1  <= bus.in_hi;
        end else if (retire) begin
            v1   <= 1'b0;
`endif
        end
    end

    // Stage 2: low word on normal loads, high word when the engine retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else if (load) begin
`ifdef NIOS_MUL_COMBINE_MULHI_EN
            out_valid_q  <= v1 & ~hi1;
`else
            out_valid_q  <= v1;
`endif
            out_result_q <= low_sum[31:0];
`ifdef NIOS_MUL_COMBINE_MULHI_EN
        end else if (retire) begin
            out_valid_q  <= 1'b1;
            out_result_q <= hi_result;
`endif
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.busy       = busy_w;

endmodule
